// File: rtl/oam_dma.sv
// Sprite-DMA engine: a CPU write to DMA_REG_ADDR halts the CPU and copies one
// 256-byte page of system RAM into OAM. Each byte takes a RAM read cycle
// followed by an OAM write cycle. The copy starts at the current OAMADDR and
// wraps within OAM.
//
// Handshake: there is no valid/ready pair on the CPU side. A trigger is a
// single-cycle cpu_write to DMA_REG_ADDR while idle. The engine answers by
// dropping cpu_ready, registered so that no CPU input reaches it
// combinationally. cpu_ready stays low until the last OAM write has retired.
module oam_dma #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_d_out,
   input  logic        cpu_write,
   input  logic [7:0]  oam_base,
   output logic        cpu_ready,
   output logic        busy,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_d_in,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_data,
   output logic        oam_we,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        par_q, par_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  oam_ptr_q, oam_ptr_d;
   logic        cpu_ready_q, cpu_ready_d;
   logic        mem_rd_q, mem_rd_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic        oam_we_q, oam_we_d;
   logic [7:0]  oam_addr_q, oam_addr_d;
   logic [7:0]  oam_data_q, oam_data_d;
   logic        trigger;

   // Only the exact register address starts a copy; reads never do.
   assign trigger = cpu_write && (cpu_addr == DMA_REG_ADDR);

   // Sequencer: next state, free-running parity, page/index/pointer bookkeeping.
   always_comb begin
      state_d   = state_q;
      par_d     = ~par_q;
      page_d    = page_q;
      idx_d     = idx_q;
      oam_ptr_d = oam_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (trigger) begin
               page_d    = cpu_d_out;
               oam_ptr_d = oam_base;
               idx_d     = 8'h00;
               state_d   = ST_HALT;
            end
         end
         // Reads must land on even-parity cycles, so an extra ALIGN cycle
         // is inserted when HALT itself falls on an even cycle.
         ST_HALT:  state_d = par_q ? ST_READ : ST_ALIGN;
         ST_ALIGN: state_d = ST_READ;
         ST_READ:  state_d = ST_WRITE;
         ST_WRITE: begin
            // Both counters wrap at 8 bits; the page byte never sees a carry.
            idx_d     = idx_q + 8'd1;
            oam_ptr_d = oam_ptr_q + 8'd1;
            state_d   = (idx_q != 8'hFF) ? ST_READ : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output registers: loaded from the upcoming state so each output is valid
   // for the whole cycle it belongs to. Addresses and data hold between bytes.
   always_comb begin
      cpu_ready_d = (state_d == ST_IDLE);
      mem_rd_d    = (state_d == ST_READ);
      mem_addr_d  = mem_rd_d ? {page_d, idx_d} : mem_addr_q;
      oam_we_d    = (state_d == ST_WRITE);
      oam_addr_d  = oam_we_d ? oam_ptr_d : oam_addr_q;
      oam_data_d  = (state_q == ST_WRITE) ? mem_d_in : oam_data_q;
   end

   // All state, asynchronously cleared; a reset mid-copy simply abandons it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         par_q       <= 1'b0;
         page_q      <= 8'h00;
         idx_q       <= 8'h00;
         oam_ptr_q   <= 8'h00;
         cpu_ready_q <= 1'b1;
         mem_rd_q    <= 1'b0;
         mem_addr_q  <= 16'h0000;
         oam_we_q    <= 1'b0;
         oam_addr_q  <= 8'h00;
         oam_data_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         par_q       <= par_d;
         page_q      <= page_d;
         idx_q       <= idx_d;
         oam_ptr_q   <= oam_ptr_d;
         cpu_ready_q <= cpu_ready_d;
         mem_rd_q    <= mem_rd_d;
         mem_addr_q  <= mem_addr_d;
         oam_we_q    <= oam_we_d;
         oam_addr_q  <= oam_addr_d;
         oam_data_q  <= oam_data_d;
      end
   end

   assign cpu_ready = cpu_ready_q;
   assign busy      = ~cpu_ready_q;
   assign mem_rd    = mem_rd_q;
   assign mem_addr  = mem_addr_q;
   assign oam_we    = oam_we_q;
   assign oam_addr  = oam_addr_q;
   // Synchronous RAM data is only valid during WRITE; pass it straight to OAM
   // then, and show the last written byte otherwise.
   assign oam_data  = (state_q == ST_WRITE) ? mem_d_in : oam_data_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: table of CPU accesses with expected halt length, a RAM
// model, an OAM/RAM-address scoreboard, plus reset-mid-transfer sequence.
module tb_oam_dma;

   localparam logic [15:0] DMA = 16'h4014;

   logic        clk, reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_d_out;
   logic        cpu_write;
   logic [7:0]  oam_base;
   logic        cpu_ready, busy, mem_rd, oam_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_d_in, oam_addr, oam_data;
   logic [2:0]  dbg_state;

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q[$];      // expected {oam_addr, oam_data}
   logic [15:0] exp_mem_q[$];  // expected mem_addr per read
   logic        par_m;         // bench's own model of the parity flop

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      logic        wr;
      logic [7:0]  base;
      logic        halt_par;  // parity wanted in the HALT cycle
      int          exp_low;   // 0 = must not trigger
      int          poke_at;   // cycle of a stray DMA write, -1 = none
   } vec_t;

   vec_t vecs[8];

   oam_dma dut (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out),
      .cpu_write(cpu_write), .oam_base(oam_base), .cpu_ready(cpu_ready),
      .busy(busy), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_d_in(mem_d_in),
      .oam_addr(oam_addr), .oam_data(oam_data), .oam_we(oam_we),
      .dbg_state(dbg_state)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] ram_val(input logic [15:0] a);
      if (a[15:8] == 8'h02) return a[7:0] ^ 8'h5A;
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   // Synchronous RAM model: data appears the cycle after the address.
   always @(posedge clk) mem_d_in <= ram_val(mem_addr);

   // Free-running parity reference.
   always @(posedge clk or posedge reset) begin
      if (reset) par_m <= 1'b0;
      else       par_m <= ~par_m;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every OAM write and every RAM read must match the queue head.
   always @(negedge clk) begin
      if (!reset) begin
         if (oam_we === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_oam_we", 32'(oam_addr), 32'hFFFF_FFFF);
            else chk("oam_write", 32'({oam_addr, oam_data}), 32'(exp_q.pop_front()));
         end
         if (mem_rd === 1'b1) begin
            chk("read_parity", 32'(par_m), 32'd0);
            if (exp_mem_q.size() == 0) chk("unexpected_mem_rd", 32'(mem_addr), 32'hFFFF_FFFF);
            else chk("mem_addr", 32'(mem_addr), 32'(exp_mem_q.pop_front()));
         end
      end
   end

   task automatic drive_idle();
      cpu_addr  = 16'h0000;
      cpu_d_out = 8'h00;
      cpu_write = 1'b0;
      oam_base  = 8'h00;
   endtask

   task automatic push_copy(input logic [7:0] page, input logic [7:0] base);
      for (int i = 0; i < 256; i++) begin
         exp_q.push_back({8'(base + 8'(i)), ram_val({page, 8'(i)})});
         exp_mem_q.push_back({page, 8'(i)});
      end
   endtask

   // Apply one access at a negedge and measure how long cpu_ready stays low.
   task automatic run_vec(input vec_t v);
      int low;
      logic busy_bad;
      // Trigger sampled on next edge; HALT parity is the opposite of now.
      if (par_m == v.halt_par) @(negedge clk);
      if (v.exp_low != 0) push_copy(v.data, v.base);
      cpu_addr  = v.addr;
      cpu_d_out = v.data;
      cpu_write = v.wr;
      oam_base  = v.base;
      @(negedge clk);
      drive_idle();
      chk("ready_after_trigger", 32'(cpu_ready), 32'(v.exp_low == 0));
      low = 0;
      busy_bad = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         if (c == v.poke_at) begin
            cpu_addr = DMA; cpu_d_out = 8'h07; cpu_write = 1'b1;
         end else if (c == v.poke_at + 1) begin
            drive_idle();
         end
         if (busy !== ~cpu_ready) busy_bad = 1'b1;
         if (cpu_ready === 1'b0) low++;
         else if (v.exp_low != 0 || c >= 20) break;
         @(negedge clk);
      end
      chk("low_cycles", 32'(low), 32'(v.exp_low));
      chk("busy_is_not_ready", 32'(busy_bad), 32'd0);
      chk("oam_writes_left", 32'(exp_q.size()), 32'd0);
      chk("mem_reads_left", 32'(exp_mem_q.size()), 32'd0);
      exp_q.delete();
      exp_mem_q.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd1);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_mem_rd"},    32'(mem_rd),    32'd0);
      chk({tag, "_oam_we"},    32'(oam_we),    32'd0);
      chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
      chk({tag, "_oam_addr"},  32'(oam_addr),  32'd0);
      chk({tag, "_oam_data"},  32'(oam_data),  32'd0);
   endtask

   initial begin
      vec_t rv;
      // addr  data  wr  base  halt_par exp_low poke
      vecs[0] = '{DMA,      8'h02, 1'b1, 8'h00, 1'b0, 514, -1}; // even HALT
      vecs[1] = '{DMA,      8'h02, 1'b1, 8'h00, 1'b1, 513, -1}; // odd HALT, back-to-back
      vecs[2] = '{DMA,      8'h03, 1'b1, 8'hF0, 1'b1, 513, -1}; // OAM wrap
      vecs[3] = '{DMA,      8'hFF, 1'b1, 8'h10, 1'b0, 514, -1}; // last page
      vecs[4] = '{16'h4013, 8'h02, 1'b1, 8'h00, 1'b0, 0,   -1}; // wrong address
      vecs[5] = '{16'h4015, 8'h02, 1'b1, 8'h00, 1'b0, 0,   -1}; // wrong address
      vecs[6] = '{DMA,      8'h02, 1'b0, 8'h00, 1'b0, 0,   -1}; // read, not write
      vecs[7] = '{DMA,      8'h02, 1'b1, 8'h00, 1'b1, 513, 50}; // write while busy

      reset = 1'b1;
      drive_idle();
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      reset = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Last transfer was page 0x02 from OAM 0: outputs hold the final byte.
      chk("hold_mem_addr", 32'(mem_addr), 32'h0000_02FF);
      chk("hold_oam_addr", 32'(oam_addr), 32'h0000_00FF);
      chk("hold_oam_data", 32'(oam_data), 32'h0000_00A5);
      chk("hold_mem_rd",   32'(mem_rd),   32'd0);
      chk("hold_oam_we",   32'(oam_we),   32'd0);

      // Reset at transfer cycle 100 must drop everything immediately.
      push_copy(8'h03, 8'h00);
      cpu_addr = DMA; cpu_d_out = 8'h03; cpu_write = 1'b1; oam_base = 8'h00;
      @(negedge clk);
      drive_idle();
      chk("mid_busy_started", 32'(cpu_ready), 32'd0);
      repeat (100) @(negedge clk);
      chk("mid_still_busy", 32'(cpu_ready), 32'd0);
      #2 reset = 1'b1;
      #1 chk_reset_outputs("midreset");
      exp_q.delete();
      exp_mem_q.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("post_reset_idle", 32'(cpu_ready), 32'd1);
      rv = '{DMA, 8'h03, 1'b1, 8'h00, 1'b0, 514, -1};
      run_vec(rv);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
